instruction_memory_dbg: RTL and testbench

Parametrised instruction memory with a registered fetch port and a debug port. The debug port supports byte-enable writes and auto-incrementing bulk load and readback. After every reset, a hardware init sequencer fills the whole array with NOP before any access is accepted. The block sits between the fetch stage and the debug/loader logic, replacing the fixed 32-bit instruction memory.

---
 rtl/instruction_memory_dbg_if.sv | 31 +++
 rtl/instruction_memory_dbg.sv | 119 +++++++++++
 tb/tb_instruction_memory_dbg.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_memory_dbg_if.sv
// Fetch and debug bus of the instruction memory. The master (fetch stage / loader)
// drives requests and the slave (memory) returns registered data and status.
interface instruction_memory_dbg_if;
  logic [31:0] addr;
  logic        read_en;
  logic [31:0] data_out;
  logic        data_valid;
  logic        fetch_fault;
  logic        init_busy;
  logic        debug_en;
  logic [31:0] debug_addr;
  logic        debug_autoinc;
  logic        debug_write_en;
  logic        debug_read_en;
  logic [3:0]  debug_byte_en;
  logic [31:0] debug_data_in;
  logic [31:0] debug_data_out;
  logic [31:0] debug_ptr;

  modport master (
    output addr, read_en, debug_en, debug_addr, debug_autoinc,
           debug_write_en, debug_read_en, debug_byte_en, debug_data_in,
    input  data_out, data_valid, fetch_fault, init_busy, debug_data_out, debug_ptr
  );

  modport slave (
    input  addr, read_en, debug_en, debug_addr, debug_autoinc,
           debug_write_en, debug_read_en, debug_byte_en, debug_data_in,
    output data_out, data_valid, fetch_fault, init_busy, debug_data_out, debug_ptr
  );
endinterface

// File: rtl/instruction_memory_dbg.sv
// Instruction memory with a registered fetch port, a byte-enable debug port with an
// auto-incrementing pointer, and a post-reset NOP fill sequencer.
module instruction_memory_dbg #(
  parameter int          DEPTH    = 256,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input logic                     clk,
  input logic                     reset,
  instruction_memory_dbg_if.slave bus
);
  localparam int              AW        = $clog2(DEPTH);
  localparam logic [32:0]     MEM_BYTES = 33'(DEPTH) * 33'd4;
  localparam logic [AW-1:0]   FILL_ONE  = 1;
  localparam logic [AW-1:0]   FILL_LAST = AW'(DEPTH - 1);

  typedef enum logic {S_INIT = 1'b0, S_READY = 1'b1} state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [AW-1:0] r_fill;
  logic [31:0]   r_mem [DEPTH];

  logic [31:0] r_data_out;
  logic        r_data_valid;
  logic        r_fetch_fault;
  logic [31:0] r_dbg_data_out;
  logic [31:0] r_ptr;

  logic          w_init_busy;
  logic          w_fill_we;
  logic          w_fetch_go;
  logic          w_dbg_go;
  logic          w_dbg_we;
  logic          w_fetch_fault;
  logic [AW-1:0] w_fetch_idx;
  logic [31:0]   w_ea;
  logic          w_ea_oob;
  logic [AW-1:0] w_ea_idx;
  logic [32:0]   w_ptr_inc;
  logic [31:0]   w_ptr_next_inc;

  // Requests carry no ready: in READY every read_en / debug_en cycle is accepted and
  // its result appears one edge later (data_valid pulses for exactly that cycle).
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_INIT;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_INIT:  if (r_fill == FILL_LAST) w_next_state = S_READY;
      S_READY: w_next_state = S_READY;
      default: w_next_state = S_INIT;
    endcase
  end

  always_comb begin
    w_init_busy = (r_state == S_INIT);
    w_fill_we   = (r_state == S_INIT) && !reset;
    w_fetch_go  = (r_state == S_READY) && !reset && bus.read_en;
    w_dbg_go    = (r_state == S_READY) && !reset && bus.debug_en;
    w_dbg_we    = w_dbg_go && bus.debug_write_en && !w_ea_oob;
  end

  assign w_fetch_idx    = bus.addr[AW+1:2];
  assign w_fetch_fault  = (bus.addr[1:0] != 2'b00) || ({1'b0, bus.addr} >= MEM_BYTES);
  assign w_ea           = bus.debug_autoinc ? r_ptr : bus.debug_addr;
  assign w_ea_oob       = ({1'b0, w_ea} >= MEM_BYTES);
  assign w_ea_idx       = w_ea[AW+1:2];
  assign w_ptr_inc      = {1'b0, r_ptr} + 33'd4;
  assign w_ptr_next_inc = (w_ptr_inc >= MEM_BYTES) ? 32'd0 : w_ptr_inc[31:0];

  always_ff @(posedge clk) begin
    if (reset) r_fill <= '0;
    else if (r_state == S_INIT) r_fill <= r_fill + FILL_ONE;
  end

  // Reads below sample r_mem before these writes land, giving read-before-write.
  always_ff @(posedge clk) begin
    if (w_fill_we) begin
      r_mem[r_fill] <= NOP_WORD;
    end else if (w_dbg_we) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.debug_byte_en[i]) r_mem[w_ea_idx][8*i +: 8] <= bus.debug_data_in[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_out     <= NOP_WORD;
      r_data_valid   <= 1'b0;
      r_fetch_fault  <= 1'b0;
      r_dbg_data_out <= 32'd0;
      r_ptr          <= 32'd0;
    end else begin
      r_data_valid <= w_fetch_go;
      if (w_fetch_go) begin
        r_fetch_fault <= w_fetch_fault;
        r_data_out    <= w_fetch_fault ? NOP_WORD : r_mem[w_fetch_idx];
      end
      if (w_dbg_go) begin
        r_dbg_data_out <= w_ea_oob ? NOP_WORD : r_mem[w_ea_idx];
        if (!bus.debug_autoinc)
          r_ptr <= {bus.debug_addr[31:2], 2'b00};
        else if (bus.debug_write_en || bus.debug_read_en)
          r_ptr <= w_ptr_next_inc;
      end
    end
  end

  assign bus.data_out       = r_data_out;
  assign bus.data_valid     = r_data_valid;
  assign bus.fetch_fault    = r_fetch_fault;
  assign bus.init_busy      = w_init_busy;
  assign bus.debug_data_out = r_dbg_data_out;
  assign bus.debug_ptr      = r_ptr;
endmodule

// File: tb/tb_instruction_memory_dbg.sv
// Bench for instruction_memory_dbg at DEPTH=16: directed scenarios plus a randomized
// run checked against a word-array model of the memory, pointer and output registers.
module tb_instruction_memory_dbg;
  localparam int          DEPTH = 16;
  localparam logic [31:0] NOP   = 32'h00000013;
  localparam int          BYTES = DEPTH * 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  instruction_memory_dbg_if bus();

  instruction_memory_dbg #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_ptr;
  logic [32:0] exp_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.addr = 0; bus.read_en = 0; bus.debug_en = 0; bus.debug_addr = 0;
    bus.debug_autoinc = 0; bus.debug_write_en = 0; bus.debug_read_en = 0;
    bus.debug_byte_en = 0; bus.debug_data_in = 0;
  endtask

  task automatic model_wipe();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = NOP;
    m_ptr = 0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Directed debug write through debug_addr (loads the pointer as a side effect).
  task automatic dbg_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.debug_en = 1; bus.debug_autoinc = 0; bus.debug_addr = a;
    bus.debug_write_en = 1; bus.debug_byte_en = be; bus.debug_data_in = d;
    tick();
    idle();
    if (a < BYTES) m_mem[a / 4] = merge(m_mem[a / 4], d, be);
    m_ptr = a & ~32'd3;
  endtask

  task automatic do_fetch(input logic [31:0] a, input logic [31:0] exp_d,
                          input logic exp_f, input string name);
    bus.read_en = 1; bus.addr = a;
    tick();
    bus.read_en = 0;
    n_cmp++;
    if (bus.data_out !== exp_d || bus.fetch_fault !== exp_f || bus.data_valid !== 1'b1) begin
      n_err++;
      $display("FAIL %s: addr=%h got data=%h fault=%b valid=%b expected data=%h fault=%b valid=1",
               name, a, bus.data_out, bus.fetch_fault, bus.data_valid, exp_d, exp_f);
    end
  endtask

  // Releases reset and counts cycles until init_busy drops; requests driven meanwhile must be ignored.
  task automatic release_and_count(input string name);
    int n;
    reset = 0;
    bus.read_en = 1; bus.addr = 0; bus.debug_en = 1; bus.debug_autoinc = 1;
    bus.debug_write_en = 1; bus.debug_byte_en = 4'hF; bus.debug_data_in = 32'hBAD0BAD0;
    n = 0;
    while (n < 64) begin
      tick();
      n++;
      n_cmp++;
      if (bus.data_valid !== 1'b0 || bus.debug_ptr !== 32'd0) begin
        n_err++;
        $display("FAIL %s_ignored: cycle %0d valid=%b ptr=%h expected valid=0 ptr=0",
                 name, n, bus.data_valid, bus.debug_ptr);
      end
      if (bus.init_busy !== 1'b1) break;
    end
    idle();
    n_cmp++;
    if (n != DEPTH) begin
      n_err++;
      $display("FAIL %s_init_len: busy for %0d cycles expected %0d", name, n, DEPTH);
    end
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    tick(); tick();
    n_cmp++;
    if (bus.data_out !== NOP || bus.data_valid !== 0 || bus.fetch_fault !== 0 ||
        bus.debug_data_out !== 0 || bus.debug_ptr !== 0 || bus.init_busy !== 1) begin
      n_err++;
      $display("FAIL reset_values: dout=%h dv=%b ff=%b ddo=%h ptr=%h busy=%b expected %h 0 0 0 0 1",
               bus.data_out, bus.data_valid, bus.fetch_fault, bus.debug_data_out,
               bus.debug_ptr, bus.init_busy, NOP);
    end
    release_and_count("reset");
    model_wipe();
  endtask

  task automatic test_fetch_all_nop();
    for (int a = 0; a < BYTES; a += 4) do_fetch(a, NOP, 1'b0, "fetch_nop");
  endtask

  task automatic test_debug_write();
    dbg_write(32'h08, 32'hCAFEBABE, 4'hF);
    bus.debug_en = 1; bus.debug_addr = 32'h08; bus.debug_read_en = 1;
    do_fetch(32'h08, 32'hCAFEBABE, 1'b0, "fetch_after_dbg_write");
    idle();
    n_cmp++;
    if (bus.debug_data_out !== 32'hCAFEBABE) begin
      n_err++;
      $display("FAIL dbg_read_full: got %h expected %h", bus.debug_data_out, 32'hCAFEBABE);
    end
    dbg_write(32'h08, 32'h11223344, 4'b0101);
    do_fetch(32'h08, 32'hCA22BA44, 1'b0, "fetch_byte_en");
    n_cmp++;
    if (m_mem[2] !== 32'hCA22BA44) begin
      n_err++;
      $display("FAIL model_byte_en: got %h expected %h", m_mem[2], 32'hCA22BA44);
    end
  endtask

  task automatic test_debug_disabled();
    bus.debug_en = 0; bus.debug_write_en = 1; bus.debug_addr = 32'h0C;
    bus.debug_byte_en = 4'hF; bus.debug_data_in = 32'hDEADBEEF;
    tick();
    idle();
    n_cmp++;
    if (bus.debug_ptr !== m_ptr || bus.debug_data_out !== 32'hCAFEBABE) begin
      n_err++;
      $display("FAIL dbg_disabled_hold: ptr=%h ddo=%h expected ptr=%h ddo=%h",
               bus.debug_ptr, bus.debug_data_out, m_ptr, 32'hCAFEBABE);
    end
    do_fetch(32'h0C, NOP, 1'b0, "dbg_disabled_no_write");
  endtask

  task automatic test_fault();
    do_fetch(32'h0A, NOP, 1'b1, "fault_misaligned");
    do_fetch(32'h40, NOP, 1'b1, "fault_oob");
    do_fetch(32'h08, m_mem[2], 1'b0, "fault_clear");
    tick();
    n_cmp++;
    if (bus.data_valid !== 0 || bus.data_out !== m_mem[2] || bus.fetch_fault !== 0) begin
      n_err++;
      $display("FAIL fetch_hold: dv=%b dout=%h ff=%b expected 0 %h 0",
               bus.data_valid, bus.data_out, bus.fetch_fault, m_mem[2]);
    end
  endtask

  task automatic test_autoinc();
    logic [31:0] vals [3];
    vals[0] = 32'hA0A0A0A0; vals[1] = 32'hB1B1B1B1; vals[2] = 32'hC2C2C2C2;
    bus.debug_en = 1; bus.debug_addr = 32'h38;
    tick();
    bus.debug_autoinc = 1; bus.debug_write_en = 1; bus.debug_byte_en = 4'hF;
    for (int i = 0; i < 3; i++) begin
      bus.debug_data_in = vals[i];
      tick();
    end
    idle();
    m_mem[14] = vals[0]; m_mem[15] = vals[1]; m_mem[0] = vals[2]; m_ptr = 32'h04;
    n_cmp++;
    if (bus.debug_ptr !== 32'h04) begin
      n_err++;
      $display("FAIL autoinc_ptr_wrap: got %h expected %h", bus.debug_ptr, 32'h04);
    end
    do_fetch(32'h38, vals[0], 1'b0, "autoinc_w0");
    do_fetch(32'h3C, vals[1], 1'b0, "autoinc_w1");
    do_fetch(32'h00, vals[2], 1'b0, "autoinc_w2");
    bus.debug_en = 1; bus.debug_addr = 32'h3B;
    tick();
    bus.debug_autoinc = 1; bus.debug_read_en = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (bus.debug_data_out !== vals[i]) begin
        n_err++;
        $display("FAIL autoinc_readback%0d: got %h expected %h", i, bus.debug_data_out, vals[i]);
      end
    end
    idle();
  endtask

  task automatic test_read_before_write();
    dbg_write(32'h10, 32'h0, 4'hF);
    bus.debug_en = 1; bus.debug_addr = 32'h10; bus.debug_write_en = 1;
    bus.debug_byte_en = 4'hF; bus.debug_data_in = 32'h1;
    do_fetch(32'h10, 32'h0, 1'b0, "rbw_fetch_old");
    idle();
    m_mem[4] = 32'h1;
    n_cmp++;
    if (bus.debug_data_out !== 32'h0) begin
      n_err++;
      $display("FAIL rbw_dbg_old: got %h expected %h", bus.debug_data_out, 32'h0);
    end
    do_fetch(32'h10, 32'h1, 1'b0, "rbw_fetch_new");
  endtask

  task automatic test_random();
    logic [31:0] m_dout, a, da, ea, exp_ddo;
    logic        m_fault, ren, den, auto, we, re, f;
    logic [3:0]  be;
    logic [32:0] e;
    m_dout = bus.data_out; m_fault = bus.fetch_fault; exp_ddo = bus.debug_data_out;
    for (int i = 0; i < 400; i++) begin
      ren = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       a = 32'($urandom_range(0, BYTES - 1)) | 32'd1;
        1:       a = 32'($urandom_range(DEPTH, 4 * DEPTH)) * 4;
        default: a = 32'($urandom_range(0, DEPTH - 1)) * 4;
      endcase
      den  = ($urandom_range(0, 3) != 0);
      auto = 1'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      re   = 1'($urandom_range(0, 1));
      be   = 4'($urandom_range(0, 15));
      da   = 32'($urandom_range(0, BYTES + 15));
      bus.read_en = ren; bus.addr = a; bus.debug_en = den; bus.debug_autoinc = auto;
      bus.debug_write_en = we; bus.debug_read_en = re; bus.debug_byte_en = be;
      bus.debug_addr = da; bus.debug_data_in = $urandom;
      if (ren) begin
        f = (a % 4 != 0) || (a >= BYTES);
        exp_q.push_back({f, f ? NOP : m_mem[a / 4]});
      end
      if (den) begin
        ea = auto ? m_ptr : da;
        exp_ddo = (ea >= BYTES) ? NOP : m_mem[ea / 4];
        if (we && ea < BYTES) m_mem[ea / 4] = merge(m_mem[ea / 4], bus.debug_data_in, be);
        if (!auto) m_ptr = da & ~32'd3;
        else if (we || re) m_ptr = (m_ptr + 4 >= BYTES) ? 32'd0 : m_ptr + 4;
      end
      tick();
      if (ren && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        m_fault = e[32]; m_dout = e[31:0];
      end
      n_cmp++;
      if (bus.data_valid !== ren || bus.data_out !== m_dout || bus.fetch_fault !== m_fault) begin
        n_err++;
        $display("FAIL rand_fetch[%0d]: dv=%b dout=%h ff=%b expected %b %h %b",
                 i, bus.data_valid, bus.data_out, bus.fetch_fault, ren, m_dout, m_fault);
      end
      n_cmp++;
      if (bus.debug_data_out !== exp_ddo || bus.debug_ptr !== m_ptr) begin
        n_err++;
        $display("FAIL rand_debug[%0d]: ddo=%h ptr=%h expected %h %h",
                 i, bus.debug_data_out, bus.debug_ptr, exp_ddo, m_ptr);
      end
    end
    idle();
  endtask

  task automatic test_reset_midway();
    dbg_write(32'h20, 32'h12345678, 4'hF);
    reset = 1;
    tick();
    n_cmp++;
    if (bus.init_busy !== 1 || bus.debug_ptr !== 0 || bus.debug_data_out !== 0) begin
      n_err++;
      $display("FAIL reset_in_ready: busy=%b ptr=%h ddo=%h expected 1 0 0",
               bus.init_busy, bus.debug_ptr, bus.debug_data_out);
    end
    reset = 0;
    for (int i = 0; i < 5; i++) tick();
    reset = 1;
    tick();
    release_and_count("reset_midfill");
    model_wipe();
    for (int a = 0; a < BYTES; a += 4) do_fetch(a, NOP, 1'b0, "wiped_nop");
  endtask

  initial begin
    test_reset();
    test_fetch_all_nop();
    test_debug_write();
    test_debug_disabled();
    test_fault();
    test_autoinc();
    test_read_before_write();
    test_random();
    test_reset_midway();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
